// File: rtl/mempipe_arb.sv
// mm0 issue-slot arbiter: round-robin with starvation escalation, registered mm1 stage.
// Optional per-requester grant counters enabled by defining MEMPIPE_ARB_PERF_EN.

package mempipe_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  op;
    logic [5:0]  tag;
  } t_mempipe_arb;
endpackage

module mempipe_arb
  import mempipe_arb_pkg::*;
#(
  parameter  int NREQ          = 3,
  parameter  int STARVE_THRESH = 15,
  localparam int CNT_W         = $clog2(STARVE_THRESH + 1),
  localparam int IDX_W         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       nuke_valid_rb1,
  input  logic [NREQ-1:0]            req_mm0,
  input  t_mempipe_arb [NREQ-1:0]    req_pkt_mm0,
  output logic [NREQ-1:0]            gnt_mm0,
  input  logic                       stall_mm1,
  output logic                       pipe_valid_mm1,
  output t_mempipe_arb               pipe_pkt_mm1,
  output logic [NREQ-1:0]            starving,
  output logic [NREQ-1:0][31:0]      perf_gnt_cnt
);

  logic                 can_accept_s;
  logic [NREQ-1:0]      starve_req_s;
  logic [NREQ-1:0]      gnt_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 found_s;
  t_mempipe_arb         win_pkt_s;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [CNT_W-1:0]     cnt_r [NREQ];

  assign can_accept_s = !stall_mm1 || !pipe_valid_mm1;
  assign starve_req_s = req_mm0 & starving;
  assign win_pkt_s    = req_pkt_mm0[win_idx_s];
  assign gnt_mm0      = gnt_s;

  // Winner selection: starving requesters first (lowest index), else round-robin after rr_ptr.
  always_comb begin
    int j;
    gnt_s     = '0;
    win_idx_s = '0;
    found_s   = 1'b0;
    j         = 0;
    if (reset && can_accept_s) begin
      if (|starve_req_s) begin
        // Descending scan so the lowest starving index is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
          win_idx_s = starve_req_s[i] ? IDX_W'(i) : win_idx_s;
        end
        found_s = 1'b1;
      end else begin
        // Farthest candidate first so the nearest requester after rr_ptr overrides it.
        for (int d = NREQ; d >= 1; d--) begin
          j = int'(rr_ptr_r) + d;
          j = (j >= NREQ) ? (j - NREQ) : j;
          win_idx_s = req_mm0[IDX_W'(j)] ? IDX_W'(j) : win_idx_s;
        end
        found_s = |req_mm0;
      end
      gnt_s = found_s ? (NREQ'(1) << win_idx_s) : '0;
    end else begin
      gnt_s     = '0;
      win_idx_s = '0;
      found_s   = 1'b0;
    end
  end

  // Round-robin pointer follows every grant, starvation grants included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r <= IDX_W'(NREQ - 1);
    end else if (found_s) begin
      rr_ptr_r <= win_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // mm1 stage register; a nuke kills the valid bit even when a grant lands the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_valid_mm1 <= 1'b0;
      pipe_pkt_mm1   <= '0;
    end else begin
      if (nuke_valid_rb1) begin
        pipe_valid_mm1 <= 1'b0;
      end else if (found_s) begin
        pipe_valid_mm1 <= 1'b1;
      end else if (can_accept_s) begin
        pipe_valid_mm1 <= 1'b0;
      end else begin
        pipe_valid_mm1 <= pipe_valid_mm1;
      end
      if (found_s) begin
        pipe_pkt_mm1 <= win_pkt_s;
      end else begin
        pipe_pkt_mm1 <= pipe_pkt_mm1;
      end
    end
  end

  // Lost-cycle counters and starving flags; stalled cycles are not counted as losses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_r[i] <= '0;
      end
      starving <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_s[i] || !req_mm0[i]) begin
          cnt_r[i] <= '0;
        end else if (can_accept_s && (cnt_r[i] != CNT_W'(STARVE_THRESH))) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
        starving[i] <= (cnt_r[i] == CNT_W'(STARVE_THRESH)) && req_mm0[i] && !gnt_s[i];
      end
    end
  end

`ifdef MEMPIPE_ARB_PERF_EN
  logic [NREQ-1:0][31:0] perf_r;

  // Free-running grant counters; nuked grants still count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_r <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        perf_r[i] <= gnt_s[i] ? (perf_r[i] + 32'd1) : perf_r[i];
      end
    end
  end

  assign perf_gnt_cnt = perf_r;
`else
  assign perf_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_mempipe_arb.sv
// Randomized bench for mempipe_arb with a queue-level reference model.
// Second instance uses STARVE_THRESH=1 so the starvation path is reachable with 3 requesters.

module tb_mempipe_arb;
  import mempipe_arb_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic nuke;
  logic stall;
  logic [N-1:0]             req_v  [2];
  t_mempipe_arb [N-1:0]     pkt_v  [2];
  logic [N-1:0]             gnt_v  [2];
  logic                     pv_v   [2];
  t_mempipe_arb             pp_v   [2];
  logic [N-1:0]             st_v   [2];
  logic [N-1:0][31:0]       perf_v [2];

  mempipe_arb u_dut (
    .clk(clk), .reset(reset), .nuke_valid_rb1(nuke),
    .req_mm0(req_v[0]), .req_pkt_mm0(pkt_v[0]), .gnt_mm0(gnt_v[0]),
    .stall_mm1(stall), .pipe_valid_mm1(pv_v[0]), .pipe_pkt_mm1(pp_v[0]),
    .starving(st_v[0]), .perf_gnt_cnt(perf_v[0])
  );

  mempipe_arb #(.STARVE_THRESH(1)) u_dut_st (
    .clk(clk), .reset(reset), .nuke_valid_rb1(nuke),
    .req_mm0(req_v[1]), .req_pkt_mm0(pkt_v[1]), .gnt_mm0(gnt_v[1]),
    .stall_mm1(stall), .pipe_valid_mm1(pv_v[1]), .pipe_pkt_mm1(pp_v[1]),
    .starving(st_v[1]), .perf_gnt_cnt(perf_v[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: last winner, lost-cycle counts, starving set, mm1 slot, grant totals.
  int            m_last [2];
  int            m_cnt  [2][N];
  bit [N-1:0]    m_st   [2];
  bit            m_val  [2];
  t_mempipe_arb  m_pkt  [2];
  int unsigned   m_perf [2][N];
  logic [N-1:0]  g_exp  [2];
  logic [N-1:0]  g_obs  [2];
  int            starve_hits = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int thr(int k);
    return (k == 0) ? 15 : 1;
  endfunction

  function automatic t_mempipe_arb rnd_pkt();
    return t_mempipe_arb'({$urandom(), 10'($urandom())});
  endfunction

  task automatic mdl_reset(int k);
    m_last[k] = N - 1;
    m_st[k]   = '0;
    m_val[k]  = 1'b0;
    m_pkt[k]  = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[k][i]  = 0;
      m_perf[k][i] = 0;
    end
  endtask

  function automatic logic [N-1:0] mdl_gnt(int k);
    logic [N-1:0] sr;
    int j;
    if (!reset || (stall && m_val[k])) return '0;
    sr = req_v[k] & m_st[k];
    if (sr != '0) begin
      for (int i = 0; i < N; i++) if (sr[i]) return N'(1) << i;
    end
    for (int d = 1; d <= N; d++) begin
      j = (m_last[k] + d) % N;
      if (req_v[k][j]) return N'(1) << j;
    end
    return '0;
  endfunction

  task automatic mdl_clock(int k, logic [N-1:0] g);
    bit ca;
    bit [N-1:0] nst;
    if (!reset) begin
      mdl_reset(k);
      return;
    end
    ca = !stall || !m_val[k];
    for (int i = 0; i < N; i++) begin
      nst[i] = (m_cnt[k][i] == thr(k)) && req_v[k][i] && !g[i];
      if (g[i] || !req_v[k][i]) m_cnt[k][i] = 0;
      else if (ca && m_cnt[k][i] < thr(k)) m_cnt[k][i]++;
    end
    m_st[k] = nst;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        m_last[k] = i;
        m_pkt[k]  = pkt_v[k][i];
`ifdef MEMPIPE_ARB_PERF_EN
        m_perf[k][i]++;
`endif
      end
    end
    if (nuke)          m_val[k] = 1'b0;
    else if (g != '0)  m_val[k] = 1'b1;
    else if (ca)       m_val[k] = 1'b0;
  endtask

  // One clock: check grant before the edge, then registered outputs just after it.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      g_exp[k] = mdl_gnt(k);
      g_obs[k] = gnt_v[k];
      check_eq($sformatf("gnt[%0d]", k), 64'(gnt_v[k]), 64'(g_exp[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) mdl_clock(k, g_exp[k]);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (m_st[k] != '0) starve_hits++;
      check_eq($sformatf("valid[%0d]", k), 64'(pv_v[k]), 64'(m_val[k]));
      check_eq($sformatf("pkt[%0d]", k), 64'(pp_v[k]), 64'(m_pkt[k]));
      check_eq($sformatf("starving[%0d]", k), 64'(st_v[k]), 64'(m_st[k]));
      for (int i = 0; i < N; i++)
        check_eq($sformatf("perf[%0d][%0d]", k, i), 64'(perf_v[k][i]), 64'(m_perf[k][i]));
    end
  endtask

  task automatic set_req(logic [N-1:0] r);
    for (int k = 0; k < 2; k++) begin
      req_v[k] = r;
      for (int i = 0; i < N; i++) pkt_v[k][i] = rnd_pkt();
    end
  endtask

  // Requesters hold until granted; a granted or idle requester may raise a fresh request.
  task automatic rnd_req();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[k][i] || g_exp[k][i]) begin
          req_v[k][i] = ($urandom_range(0, 99) < 70);
          pkt_v[k][i] = rnd_pkt();
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] rr_seq [4];
    t_mempipe_arb saved;
    int unsigned  perf_exp;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

    reset = 1'b0; nuke = 1'b0; stall = 1'b0;
    set_req(3'b111);
    for (int k = 0; k < 2; k++) mdl_reset(k);
    step();
    step();
    check_eq("reset_valid", 64'(pv_v[0]), 64'd0);
    check_eq("reset_gnt", 64'(g_obs[0]), 64'd0);
    reset = 1'b1;

    // Full load rotates 0,1,2,0 and mm1 fills on the first grant.
    for (int c = 0; c < 4; c++) begin
      set_req(3'b111);
      step();
      check_eq($sformatf("rr_seq%0d", c), 64'(g_obs[0]), 64'(rr_seq[c]));
      check_eq("rr_valid", 64'(pv_v[0]), 64'd1);
    end

    // Stall with mm1 occupied: no grant, packet held, grant on first free cycle.
    set_req(3'b010);
    step();
    saved = pkt_v[0][1];
    stall = 1'b1;
    set_req(3'b010);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("stall_gnt", 64'(g_obs[0]), 64'd0);
      check_eq("stall_pkt", 64'(pp_v[0]), 64'(saved));
    end
    stall = 1'b0;
    step();
    check_eq("unstall_gnt", 64'(g_obs[0]), 64'(3'b010));

    // Nuke alongside a grant: grant visible, mm1 killed.
    set_req(3'b010);
    nuke = 1'b1;
    step();
    check_eq("nuke_gnt", 64'(g_obs[0]), 64'(3'b010));
    check_eq("nuke_valid", 64'(pv_v[0]), 64'd0);
    nuke = 1'b0;

    // Randomized traffic with stalls, nukes and occasional resets.
    set_req(3'b000);
    for (int c = 0; c < 1500; c++) begin
      stall = ($urandom_range(0, 99) < 25);
      nuke  = ($urandom_range(0, 99) < 5);
      reset = ($urandom_range(0, 199) != 0);
      step();
      rnd_req();
    end
    stall = 1'b0; nuke = 1'b0; reset = 1'b1;
    if (starve_hits == 0) $display("note: starvation path not exercised by random traffic");

    // Reset while busy, then first grant goes to requester 0.
    set_req(3'b111);
    step();
    reset = 1'b0;
    step();
    check_eq("rst_valid", 64'(pv_v[0]), 64'd0);
    check_eq("rst_starving", 64'(st_v[1]), 64'd0);
    check_eq("rst_gnt", 64'(g_obs[0]), 64'd0);
    reset = 1'b1;
    step();
    check_eq("rst_first_gnt", 64'(g_obs[0]), 64'(3'b001));

    // Ten grants to requester 2 after a clean reset.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_req(3'b100);
      step();
    end
`ifdef MEMPIPE_ARB_PERF_EN
    perf_exp = 10;
`else
    perf_exp = 0;
`endif
    check_eq("perf2", 64'(perf_v[0][2]), 64'(perf_exp));
    check_eq("perf0", 64'(perf_v[0][0]), 64'd0);
    check_eq("perf1", 64'(perf_v[0][1]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
